rc5_sched: RTL and testbench

RC5_SCHED -- requirements
Module: rc5_sched

---
 rtl/rc5_sched_pkg.sv | 24 ++
 rtl/rc5_sched_s_table.sv | 49 ++++
 rtl/rc5_sched.sv | 199 +++++++++++++++++++
 tb/tb_rc5_sched.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rc5_sched_pkg.sv
// Shared definitions for the RC5 block scheduler: FSM encoding and S-table sizing.
package rc5_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_KEYGEN   = 3'd1,
    ST_READY    = 3'd2,
    ST_LOAD     = 3'd3,
    ST_START    = 3'd4,
    ST_RUN      = 3'd5,
    ST_WAIT_OUT = 3'd6
  } state_e;

  // Number of S-table entries for a given round count.
  function automatic int rc5_t(input int r);
    return 2 * (r + 1);
  endfunction

  // Address width needed to index the S-table.
  function automatic int rc5_tl(input int r);
    return $clog2(2 * (r + 1));
  endfunction

endpackage

// File: rtl/rc5_sched_s_table.sv
// S-table: T x W storage, one write port, two registered read ports.
// Contents have no reset; only the read registers are cleared.
module s_table #(
  parameter int W  = 32,
  parameter int T  = 26,
  parameter int TL = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [TL-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [TL-1:0] raddr1,
  input  logic [TL-1:0] raddr2,
  output logic [W-1:0]  rdata1,
  output logic [W-1:0]  rdata2
);

  localparam logic [TL:0] DEPTH = (TL + 1)'(T);

  logic [W-1:0] mem [T];
  logic [W-1:0] rdata1_q, rdata1_d, rdata2_q, rdata2_d;

  // Addresses past T (when T is not a power of two) read as zero and never write.
  always_comb begin
    rdata1_d = ({1'b0, raddr1} < DEPTH) ? mem[raddr1] : '0;
    rdata2_d = ({1'b0, raddr2} < DEPTH) ? mem[raddr2] : '0;
  end

  // Storage array write; deliberately not reset so a key survives a block abort.
  always_ff @(posedge clk) begin
    if (we && ({1'b0, waddr} < DEPTH)) mem[waddr] <= wdata;
  end

  // Read data registers give exactly one cycle of read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata1_q <= '0;
      rdata2_q <= '0;
    end else begin
      rdata1_q <= rdata1_d;
      rdata2_q <= rdata2_d;
    end
  end

  assign rdata1 = rdata1_q;
  assign rdata2 = rdata2_q;

endmodule

// File: rtl/rc5_sched.sv
// RC5 scheduler: sequences key expansion and block encryption between an
// external key expander and cipher core, owns the S-table and the I/O buffers.
module rc5_sched
  import rc5_sched_pkg::*;
#(
  parameter  int W       = 32,
  parameter  int R       = 12,
  parameter  int TIMEOUT = 1023,
  localparam int T       = rc5_t(R),
  localparam int TL      = rc5_tl(R)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          iKeyLoad,
  output logic          oKeyReady,
  input  logic          iValid,
  input  logic [W-1:0]  iA,
  input  logic [W-1:0]  iB,
  output logic          oReady,
  output logic          oValid,
  output logic [W-1:0]  oA,
  output logic [W-1:0]  oB,
  input  logic          iReady,
  output logic          oKeyStart,
  input  logic          iKeyDone,
  input  logic          iKeyWe,
  input  logic [TL-1:0] iKeyAddr,
  input  logic [W-1:0]  iKeyWdata,
  output logic [W-1:0]  oKeyRdata,
  output logic          oCipherRst,
  output logic          oCipherStart,
  output logic [W-1:0]  oCipherA,
  output logic [W-1:0]  oCipherB,
  input  logic [TL-1:0] iCipherAddr1,
  input  logic [TL-1:0] iCipherAddr2,
  output logic [W-1:0]  oS_sub_i1,
  output logic [W-1:0]  oS_sub_i2,
  input  logic          iCipherDone,
  input  logic [W-1:0]  iCipherA,
  input  logic [W-1:0]  iCipherB,
  output logic          oError,
  output logic [15:0]   oBlockCount
);

  localparam int            CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          key_pend_q, key_pend_d;
  logic          key_start_q, key_start_d;
  logic          cipher_rst_q, cipher_rst_d;
  logic          cipher_start_q, cipher_start_d;
  logic          err_q, err_d;
  logic          vld_q, vld_d;
  logic [W-1:0]  oa_q, oa_d, ob_q, ob_d, ca_q, ca_d, cb_q, cb_d;
  logic [15:0]   blk_q, blk_d;

  logic          out_free, out_take, accept, capture, timed, tmo, busy;
  logic          tbl_we;
  logic [TL-1:0] tbl_raddr1;
  logic [W-1:0]  rdata1;

  // State register; reset discards any block in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic; tmo flags a watchdog expiry on this cycle.
  always_comb begin
    state_d = state_q;
    tmo     = 1'b0;
    unique case (state_q)
      ST_IDLE:     if (iKeyLoad) state_d = ST_KEYGEN;
      ST_KEYGEN: begin
        if (iKeyDone) state_d = ST_READY;
        else if (timed) begin
          state_d = ST_IDLE;
          tmo     = 1'b1;
        end
      end
      ST_READY: begin
        if (key_pend_q || iKeyLoad) state_d = ST_KEYGEN;
        else if (accept)            state_d = ST_LOAD;
      end
      ST_LOAD:     state_d = ST_START;
      ST_START:    state_d = ST_RUN;
      ST_RUN: begin
        if (iCipherDone) state_d = out_free ? ST_READY : ST_WAIT_OUT;
        else if (timed) begin
          state_d = ST_IDLE;
          tmo     = 1'b1;
        end
      end
      ST_WAIT_OUT: if (iReady) state_d = ST_READY;
      default:     state_d = ST_IDLE;
    endcase
  end

  // State-decoded outputs and S-table port steering.
  always_comb begin
    out_free   = !vld_q || iReady;
    out_take   = vld_q && iReady;
    busy       = (state_q == ST_LOAD) || (state_q == ST_START) ||
                 (state_q == ST_RUN)  || (state_q == ST_WAIT_OUT);
    // A pending or arriving key request wins over new plaintext.
    oReady     = (state_q == ST_READY) && !key_pend_q && !iKeyLoad && out_free;
    accept     = iValid && oReady;
    oKeyReady  = (state_q != ST_IDLE) && (state_q != ST_KEYGEN);
    timed      = ((state_q == ST_KEYGEN) || (state_q == ST_RUN)) && (cnt_q == CNT_LAST);
    capture    = (((state_q == ST_RUN) && iCipherDone) || (state_q == ST_WAIT_OUT)) && out_free;
    tbl_we     = (state_q == ST_KEYGEN) && iKeyWe;
    tbl_raddr1 = (state_q == ST_KEYGEN) ? iKeyAddr : iCipherAddr1;
  end

  // Datapath next values: watchdog, pending key, pulses, buffers, counter.
  always_comb begin
    cnt_d = (((state_q == ST_KEYGEN) || (state_q == ST_RUN)) && (state_d == state_q)) ?
            cnt_q + 1'b1 : '0;
    key_pend_d = key_pend_q;
    if (iKeyLoad && busy) key_pend_d = 1'b1;
    if ((state_d == ST_KEYGEN) || (state_d == ST_IDLE)) key_pend_d = 1'b0;
    key_start_d    = (state_d == ST_KEYGEN) && (state_q != ST_KEYGEN);
    cipher_rst_d   = (state_d == ST_LOAD) || tmo;
    cipher_start_d = (state_d == ST_START);
    err_d          = err_q || tmo;
    ca_d           = accept ? iA : ca_q;
    cb_d           = accept ? iB : cb_q;
    vld_d          = vld_q;
    oa_d           = oa_q;
    ob_d           = ob_q;
    if (capture) begin
      vld_d = 1'b1;
      oa_d  = iCipherA;
      ob_d  = iCipherB;
    end else if (out_take) begin
      vld_d = 1'b0;
    end
    blk_d = blk_q + 16'(out_take);
  end

  // Datapath registers; the cipher core is held in reset while we are.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q          <= '0;
      key_pend_q     <= 1'b0;
      key_start_q    <= 1'b0;
      cipher_rst_q   <= 1'b1;
      cipher_start_q <= 1'b0;
      err_q          <= 1'b0;
      vld_q          <= 1'b0;
      oa_q           <= '0;
      ob_q           <= '0;
      ca_q           <= '0;
      cb_q           <= '0;
      blk_q          <= '0;
    end else begin
      cnt_q          <= cnt_d;
      key_pend_q     <= key_pend_d;
      key_start_q    <= key_start_d;
      cipher_rst_q   <= cipher_rst_d;
      cipher_start_q <= cipher_start_d;
      err_q          <= err_d;
      vld_q          <= vld_d;
      oa_q           <= oa_d;
      ob_q           <= ob_d;
      ca_q           <= ca_d;
      cb_q           <= cb_d;
      blk_q          <= blk_d;
    end
  end

  s_table #(.W(W), .T(T), .TL(TL)) u_s_table (
    .clk    (clk),
    .rst_n  (rst),
    .we     (tbl_we),
    .waddr  (iKeyAddr),
    .wdata  (iKeyWdata),
    .raddr1 (tbl_raddr1),
    .raddr2 (iCipherAddr2),
    .rdata1 (rdata1),
    .rdata2 (oS_sub_i2)
  );

  assign oKeyRdata    = rdata1;
  assign oS_sub_i1    = rdata1;
  assign oKeyStart    = key_start_q;
  assign oCipherRst   = cipher_rst_q;
  assign oCipherStart = cipher_start_q;
  assign oCipherA     = ca_q;
  assign oCipherB     = cb_q;
  assign oValid       = vld_q;
  assign oA           = oa_q;
  assign oB           = ob_q;
  assign oError       = err_q;
  assign oBlockCount  = blk_q;

endmodule

// File: tb/tb_rc5_sched.sv
// Directed bench for rc5_sched; the bench plays key expander and cipher core,
// and a scoreboard checks every ciphertext handed downstream.
module tb_rc5_sched;

  localparam int W  = 32;
  localparam int R  = 12;
  localparam int TL = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b0, rst2 = 1'b0;
  logic          key_load = 1'b0, key_done = 1'b0, key_we = 1'b0;
  logic          key_load2 = 1'b0, key_done2 = 1'b0, vld2 = 1'b0;
  logic [TL-1:0] key_addr = '0, caddr1 = '0, caddr2 = '0;
  logic [W-1:0]  key_wdata = '0, ia = '0, ib = '0, ca = '0, cb = '0;
  logic          vld = 1'b0, out_rdy = 1'b0, cdone = 1'b0;

  logic          key_ready, rdy, ovld, key_start, crst, cstart, err;
  logic [W-1:0]  oa, ob, coa, cob, krd, s1, s2;
  logic [15:0]   bcnt;
  logic          key_ready2, rdy2, ovld2, key_start2, crst2, cstart2, err2;
  logic [W-1:0]  oa2, ob2, coa2, cob2, krd2, s1b, s2b;
  logic [15:0]   bcnt2;

  rc5_sched #(.W(W), .R(R), .TIMEOUT(100)) u_dut (
    .clk(clk), .rst(rst), .iKeyLoad(key_load), .oKeyReady(key_ready),
    .iValid(vld), .iA(ia), .iB(ib), .oReady(rdy),
    .oValid(ovld), .oA(oa), .oB(ob), .iReady(out_rdy),
    .oKeyStart(key_start), .iKeyDone(key_done), .iKeyWe(key_we), .iKeyAddr(key_addr),
    .iKeyWdata(key_wdata), .oKeyRdata(krd),
    .oCipherRst(crst), .oCipherStart(cstart), .oCipherA(coa), .oCipherB(cob),
    .iCipherAddr1(caddr1), .iCipherAddr2(caddr2), .oS_sub_i1(s1), .oS_sub_i2(s2),
    .iCipherDone(cdone), .iCipherA(ca), .iCipherB(cb),
    .oError(err), .oBlockCount(bcnt)
  );

  rc5_sched #(.W(W), .R(R), .TIMEOUT(15)) u_tmo (
    .clk(clk), .rst(rst2), .iKeyLoad(key_load2), .oKeyReady(key_ready2),
    .iValid(vld2), .iA(ia), .iB(ib), .oReady(rdy2),
    .oValid(ovld2), .oA(oa2), .oB(ob2), .iReady(out_rdy),
    .oKeyStart(key_start2), .iKeyDone(key_done2), .iKeyWe(key_we), .iKeyAddr(key_addr),
    .iKeyWdata(key_wdata), .oKeyRdata(krd2),
    .oCipherRst(crst2), .oCipherStart(cstart2), .oCipherA(coa2), .oCipherB(cob2),
    .iCipherAddr1(caddr1), .iCipherAddr2(caddr2), .oS_sub_i1(s1b), .oS_sub_i2(s2b),
    .iCipherDone(cdone), .iCipherA(ca), .iCipherB(cb),
    .oError(err2), .oBlockCount(bcnt2)
  );

  int checks = 0, errors = 0;
  int mdl_cnt = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one plaintext and walk it through LOAD/START into RUN.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    vld = 1'b1; ia = a; ib = b;
    #1;
    check("accept_ready", 64'(rdy), 64'd1);
    tick();
    vld = 1'b0;
    check("load_crst", 64'(crst), 64'd1);
    check("load_cipher_ab", {coa, cob}, {a, b});
    tick();
    check("start_pulse", 64'({crst, cstart}), 64'd1);
    tick();
    check("run_cstart_low", 64'(cstart), 64'd0);
  endtask

  // Cipher core reports completion; expected output goes to the scoreboard.
  task automatic finish(input logic [W-1:0] a, input logic [W-1:0] b);
    cdone = 1'b1; ca = a; cb = b;
    exp_q.push_back({a, b});
    tick();
    cdone = 1'b0;
    check("cap_valid", 64'(ovld), 64'd1);
    check("cap_ab", {oa, ob}, {a, b});
  endtask

  // Scoreboard: every downstream handshake must match the oldest expectation.
  always @(negedge clk) begin
    if (rst && ovld && out_rdy) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL sb_unexpected observed=%0h expected=empty", {oa, ob});
      end
      if (exp_q.size() > 0) begin
        check("sb_data", {oa, ob}, exp_q.pop_front());
        mdl_cnt++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    // Reset values
    repeat (2) tick();
    check("rst_key_ready", 64'(key_ready), 64'd0);
    check("rst_ready", 64'(rdy), 64'd0);
    check("rst_valid", 64'(ovld), 64'd0);
    check("rst_oab", {oa, ob}, 64'd0);
    check("rst_cab", {coa, cob}, 64'd0);
    check("rst_crst", 64'(crst), 64'd1);
    check("rst_pulses", 64'({key_start, cstart}), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_bcnt", 64'(bcnt), 64'd0);

    // Key expansion: done after 20 cycles, ready on cycle 21
    rst = 1'b1;
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
    check("kstart_hi", 64'(key_start), 64'd1);
    check("keygen_not_ready", 64'(key_ready), 64'd0);
    for (int k = 0; k < 19; k++) begin
      key_we = 1'b1; key_addr = TL'(k);
      key_wdata = (k == 3) ? 32'hA5A5_0003 : (k == 4) ? 32'h5A5A_0004 : 32'h0;
      tick();
      if (k == 0) check("kstart_one_cycle", 64'(key_start), 64'd0);
    end
    check("keygen_c20", 64'(key_ready), 64'd0);
    key_we = 1'b0; key_addr = TL'(3); key_done = 1'b1;
    tick();
    key_done = 1'b0;
    check("key_ready_c21", 64'(key_ready), 64'd1);
    check("key_rdata", 64'(krd), 64'hA5A5_0003);
    check("ready_after_key", 64'(rdy), 64'd1);

    // Cipher-side reads, write port locked outside KEYGEN
    key_we = 1'b1; key_addr = TL'(3); key_wdata = 32'hFFFF_FFFF;
    caddr1 = TL'(3); caddr2 = TL'(4);
    tick();
    key_we = 1'b0;
    check("s_rd1", 64'(s1), 64'hA5A5_0003);
    check("s_rd2", 64'(s2), 64'h5A5A_0004);
    tick();
    check("s_wr_blocked", 64'(s1), 64'hA5A5_0003);

    // Block 1: zero plaintext, immediate drain
    out_rdy = 1'b1;
    send(32'h0, 32'h0);
    finish(32'h1111_1111, 32'h2222_2222);
    tick();
    check("blk1_drained", 64'(ovld), 64'd0);
    check("blk_cnt_1", 64'(bcnt), 64'(mdl_cnt));

    // Block 2 held downstream: output stable, new input stalled
    out_rdy = 1'b0;
    send(32'hAAAA_0001, 32'hBBBB_0001);
    finish(32'hC2C2_000A, 32'hC2C2_000B);
    vld = 1'b1; ia = 32'hAAAA_0002; ib = 32'hBBBB_0002;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("hold_valid", 64'(ovld), 64'd1);
      check("hold_ab", {oa, ob}, 64'hC2C2_000A_C2C2_000B);
      check("hold_stall", 64'(rdy), 64'd0);
      check("hold_cipher_ab", {coa, cob}, 64'hAAAA_0001_BBBB_0001);
    end
    // Drain block 2 and accept block 3 on the same edge
    out_rdy = 1'b1;
    send(32'hAAAA_0002, 32'hBBBB_0002);
    finish(32'hC3C3_000A, 32'hC3C3_000B);
    tick();
    check("blk_cnt_3", 64'(bcnt), 64'(mdl_cnt));

    // Key load during RUN: block completes, KEYGEN before new input
    send(32'h4444_0001, 32'h4444_0002);
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
    finish(32'hC4C4_000A, 32'hC4C4_000B);
    check("pend_blocks_ready", 64'(rdy), 64'd0);
    tick();
    check("pend_kstart", 64'(key_start), 64'd1);
    check("pend_key_ready", 64'(key_ready), 64'd0);
    key_load = 1'b1; key_done = 1'b1;
    tick();
    key_load = 1'b0; key_done = 1'b0;
    check("rekey_ready", 64'(key_ready), 64'd1);
    check("rekey_kstart_low", 64'(key_start), 64'd0);
    tick();
    check("keygen_load_ignored", 64'(rdy), 64'd1);
    check("blk_cnt_4", 64'(bcnt), 64'(mdl_cnt));

    // Reset mid-RUN discards the block
    send(32'h5555_0001, 32'h5555_0002);
    tick();
    rst = 1'b0;
    #1;
    check("mid_rst_valid", 64'(ovld), 64'd0);
    check("mid_rst_oab", {oa, ob}, 64'd0);
    check("mid_rst_cab", {coa, cob}, 64'd0);
    check("mid_rst_crst", 64'(crst), 64'd1);
    check("mid_rst_pulses", 64'({key_start, cstart}), 64'd0);
    check("mid_rst_ready", 64'({key_ready, rdy}), 64'd0);
    check("mid_rst_err", 64'(err), 64'd0);
    check("mid_rst_bcnt", 64'(bcnt), 64'd0);
    mdl_cnt = 0;
    tick();
    tick();
    rst = 1'b1;
    cdone = 1'b1; ca = 32'hDEAD_0001; cb = 32'hDEAD_0002;
    repeat (4) tick();
    cdone = 1'b0;
    check("post_rst_no_valid", 64'(ovld), 64'd0);

    // Watchdog on a 15-cycle instance: cipher never finishes
    rst2 = 1'b1;
    key_load2 = 1'b1;
    tick();
    key_load2 = 1'b0;
    repeat (4) tick();
    key_done2 = 1'b1;
    tick();
    key_done2 = 1'b0;
    check("tmo_key_ready", 64'(key_ready2), 64'd1);
    vld2 = 1'b1; ia = 32'h0; ib = 32'h0;
    #1;
    check("tmo_accept_ready", 64'(rdy2), 64'd1);
    tick();
    vld2 = 1'b0;
    tick();
    tick();
    repeat (14) tick();
    check("tmo_not_yet", 64'(err2), 64'd0);
    tick();
    check("tmo_err", 64'(err2), 64'd1);
    check("tmo_key_ready_low", 64'(key_ready2), 64'd0);
    check("tmo_crst", 64'(crst2), 64'd1);
    check("tmo_buf_untouched", 64'(ovld2), 64'd0);
    tick();
    check("tmo_crst_one_cycle", 64'(crst2), 64'd0);
    check("tmo_err_sticky", 64'(err2), 64'd1);
    key_load2 = 1'b1;
    tick();
    key_load2 = 1'b0;
    check("tmo_functional", 64'(key_start2), 64'd1);

    check("sb_drain", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
